regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (en/wa/wd) between NREQ writeback sources, e.g. ALU result, load return and CSR read.
- Round-robin grant, valid/ready handshake per requester, registered output stage feeding the register file.
- Suppresses writes to x0 so the register file never sees en=1 with wa=0.

Parameters:
NREQ, 3, number of writeback requesters (1..8)
AW, 5, register address width
DW, 32, write data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
hold  input  1  pipeline stall; no grant issued while high
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant (combinational, one-hot or zero)
req_addr  input  NREQ*AW  packed destination addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
rf_en  output  1  register file write enable (registered)
rf_wa  output  AW  register file write address (registered)
rf_wd  output  DW  register file write data (registered)
wb_busy  output  1  high when any req_valid is high or rf_en is high

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - rf_en=0, rf_wa=0, rf_wd=0.
  - Round-robin pointer ptr=0; requester 0 has first priority.
  - req_ready is 0 for the whole cycle in which rst_n=0.
- Handshake: a transfer occurs on requester i when req_valid[i] && req_ready[i] at a clk edge.
  - Once valid is raised, the requester holds valid, addr and data stable until the transfer.
  - valid never drops before the transfer.
- Grant (combinational):
  - If hold=1 or rst_n=0, req_ready=0.
  - Otherwise search requesters ptr, ptr+1, … wrapping mod NREQ.
  - The first one with valid set gets req_ready=1; all others get 0.
  - At most one ready bit is high per cycle.
- Pointer update: on a transfer to requester i, ptr <= (i+1) mod NREQ. With no transfer, ptr holds.
- Output stage: the register file accepts every cycle, so the stage never back-pressures.
  - On a transfer: rf_wa <= addr_i, rf_wd <= data_i, rf_en <= (addr_i != 0).
  - With no transfer: rf_en <= 0; rf_wa and rf_wd hold their previous values.
  - Latency is exactly 1 cycle from handshake to rf_en, i.e. the register file commits on the following edge.
- x0 rule: a request to address 0 still completes its handshake (ready=1, ptr advances) but produces rf_en=0.
- Throughput: 1 write per cycle. With all NREQ valid continuously, each requester is granted once every NREQ cycles.
- hold: grants stop in the same cycle hold rises. A write already in the output stage still reaches the register file.
- NREQ=1: degenerates to req_ready = !hold && req_valid; ptr stays 0.
- Reset mid-operation: outstanding requests are not granted during reset. The requester keeps valid and is re-arbitrated from ptr=0 after reset.
- Same address from two requesters in consecutive grants: both writes issue in grant order; the last one wins in the register file.

Optional Feature:
- Macro: RF_WB_PERF_EN.
- Defined:
  - Adds output conflict_cnt (16-bit).
  - Increments by 1 each cycle in which hold=0 and two or more req_valid bits are high.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rf_pkg holds:
  - RF_AW=5, RF_DW=32, RF_DEPTH=32, RF_ZERO_ADDR=5'd0.
  - Typedefs rf_addr_t (logic [RF_AW-1:0]) and rf_data_t (logic [RF_DW-1:0]).
- Sub-module rr_arbiter: NREQ-wide round-robin grant logic plus the ptr register, with inputs req, en and advance, and output one-hot grant.
- The top level adds the address/data mux, the output register stage and the x0 rule.

Test Plan:
1. Reset, then valid=3'b001, addr0=5'd7, data0=32'hDEADBEEF → ready=3'b001 that cycle; next cycle rf_en=1, rf_wa=7, rf_wd=DEADBEEF; the cycle after, rf_en=0.
2. All three valid held for 6 cycles → grant order 0,1,2,0,1,2; rf_en=1 on all 6 following cycles; no ready bit high twice within any 3 cycles.
3. Requester 1 with addr=0, data=32'h12345678 → ready[1]=1 and ptr advances to 2; rf_en stays 0 in the next cycle.
4. valid=3'b110 with hold=1 for 4 cycles → ready=0 throughout and rf_en=0; hold drops → requester 1 granted first (ptr=0, requester 0 idle), requester 2 granted next cycle.
5. rst_n=0 asserted the cycle after a grant to requester 2 → rf_en=0 and ptr=0 after the edge; with valid=3'b111 after release, requester 0 is granted first.
6. With RF_WB_PERF_EN defined: 10 cycles of valid=3'b011, hold=0, then 3 cycles with hold=1 → conflict_cnt=10; preload near saturation (force) → holds at 16'hFFFF.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the writeback path.
package rf_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 32;

    localparam logic [RF_AW-1:0] RF_ZERO_ADDR = 5'd0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; the priority pointer moves past the
// most recent winner whenever a grant is taken.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gnt_idx;
    logic          w_found;

    // Scan from r_ptr upward with wrap; first asserted request wins.
    always_comb begin
        grant     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        if (en) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (!w_found && req[i] &&
                        ((int'(r_ptr) + k) % int'(NREQ) == i)) begin
                        grant[i]  = 1'b1;
                        w_gnt_idx = PW'(i);
                        w_found   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback sources onto the single register-file write port,
// with a registered output stage and x0 write suppression.
// Optional conflict counter enabled by defining RF_WB_PERF_EN.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned DW   = RF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_en,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic               wb_busy
`ifdef RF_WB_PERF_EN
    ,
    output logic [15:0]        conflict_cnt
`endif
);

    logic [NREQ-1:0] w_grant;
    logic            w_arb_en;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    logic            r_rf_en;
    logic [AW-1:0]   r_rf_wa;
    logic [DW-1:0]   r_rf_wd;

    // Grants are suppressed both while stalled and throughout the reset cycle.
    assign w_arb_en = rst_n & ~hold;
    assign w_xfer   = |w_grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (w_arb_en),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // A write to x0 still handshakes but never raises the register-file enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_en <= 1'b0;
            r_rf_wa <= '0;
            r_rf_wd <= '0;
        end else if (w_xfer) begin
            r_rf_en <= (w_sel_addr != AW'(RF_ZERO_ADDR));
            r_rf_wa <= w_sel_addr;
            r_rf_wd <= w_sel_data;
        end else begin
            r_rf_en <= 1'b0;
        end
    end

    assign rf_en   = r_rf_en;
    assign rf_wa   = r_rf_wa;
    assign rf_wd   = r_rf_wd;
    assign wb_busy = (|req_valid) | r_rf_en;

`ifdef RF_WB_PERF_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] r_conflict_cnt;
    logic             w_conflict;

    assign w_conflict = ~hold && ($countones(req_valid) >= 2);

    // Saturating count of cycles with more than one contender.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
